ram_latency_dual: RTL and testbench

//  Next-generation instruction/data memory for the RISC-V core. Parametrised dual-port RAM

---
 rtl/ram_latency_dual_pkg.sv | 21 ++
 rtl/ram_latency_dual_port_ctrl.sv | 60 ++++++
 rtl/ram_latency_dual.sv | 118 +++++++++++
 tb/tb_ram_latency_dual.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_latency_dual_pkg.sv
// rtl/ram_latency_dual_pkg.sv - shared types and helpers for the dual-port latency RAM
package ram_latency_dual_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } port_state_t;

   localparam int LAT_CNT_WIDTH = 4;

   function automatic int ram_clog2(input int value);
      int result;
      result = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         result++;
      end
      return result;
   endfunction

endpackage

// File: rtl/ram_latency_dual_port_ctrl.sv
// rtl/ram_latency_dual_port_ctrl.sv - per-port handshake FSM with latency counter
module ram_latency_dual_port_ctrl
   import ram_latency_dual_pkg::*;
#(
   parameter int READ_LATENCY = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic req,
   output logic ready,
   output logic accept,
   output logic resp_load,
   output logic valid
);

   // Counter preload so that WAIT lasts READ_LATENCY-1 cycles before RESP.
   localparam logic [LAT_CNT_WIDTH-1:0] WAIT_LOAD =
      LAT_CNT_WIDTH'((READ_LATENCY >= 2) ? (READ_LATENCY - 2) : 0);

   port_state_t              state;
   logic [LAT_CNT_WIDTH-1:0] cnt;

   assign ready     = (state == ST_IDLE) || (state == ST_RESP);
   assign accept    = req && ready;
   assign resp_load = (accept && (READ_LATENCY == 1)) ||
                      ((state == ST_WAIT) && (cnt == '0));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
         cnt   <= '0;
         valid <= 1'b0;
      end else begin
         valid <= resp_load;
         case (state)
            ST_IDLE, ST_RESP: begin
               if (accept) begin
                  if (READ_LATENCY == 1) begin
                     state <= ST_RESP;
                  end else begin
                     state <= ST_WAIT;
                     cnt   <= WAIT_LOAD;
                  end
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_WAIT: begin
               if (cnt == '0) begin
                  state <= ST_RESP;
               end else begin
                  cnt <= cnt - LAT_CNT_WIDTH'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/ram_latency_dual.sv
// rtl/ram_latency_dual.sv - dual-port I/D RAM with byte stores and configurable latency
module ram_latency_dual
   import ram_latency_dual_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 16,
   parameter int INDEX_WIDTH  = 10,
   parameter int READ_LATENCY = 2
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    i_req,
   input  logic [ADDR_WIDTH-1:0]   i_address,
   output logic                    i_ready,
   output logic                    i_valid,
   output logic [DATA_WIDTH-1:0]   i_read_data,
   input  logic                    d_req,
   input  logic                    wEn,
   input  logic [DATA_WIDTH/8-1:0] d_byte_en,
   input  logic [ADDR_WIDTH-1:0]   d_address,
   input  logic [DATA_WIDTH-1:0]   d_write_data,
   output logic                    d_ready,
   output logic                    d_valid,
   output logic [DATA_WIDTH-1:0]   d_read_data,
   output logic                    d_err
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int OFS   = ram_clog2(BYTES);
   localparam int DEPTH = 2 ** INDEX_WIDTH;
   localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH + 1)'(DEPTH * BYTES);

   logic [DATA_WIDTH-1:0]  mem [DEPTH];

   logic                   i_accept, i_load;
   logic                   d_accept, d_load;
   logic [INDEX_WIDTH-1:0] i_idx, d_idx;
   logic                   i_oob, d_oob, d_commit;
   logic [DATA_WIDTH-1:0]  d_word, d_merged, i_fresh, d_fresh;
   logic [DATA_WIDTH-1:0]  i_pend, d_pend;
   logic                   d_pend_err;

   ram_latency_dual_port_ctrl #(.READ_LATENCY(READ_LATENCY)) u_i_ctrl (
      .clock     (clock),
      .reset     (reset),
      .req       (i_req),
      .ready     (i_ready),
      .accept    (i_accept),
      .resp_load (i_load),
      .valid     (i_valid)
   );

   ram_latency_dual_port_ctrl #(.READ_LATENCY(READ_LATENCY)) u_d_ctrl (
      .clock     (clock),
      .reset     (reset),
      .req       (d_req),
      .ready     (d_ready),
      .accept    (d_accept),
      .resp_load (d_load),
      .valid     (d_valid)
   );

   assign i_idx  = i_address[INDEX_WIDTH+OFS-1:OFS];
   assign d_idx  = d_address[INDEX_WIDTH+OFS-1:OFS];
   assign i_oob  = {1'b0, i_address} >= MEM_BYTES;
   assign d_oob  = {1'b0, d_address} >= MEM_BYTES;
   assign d_word = mem[d_idx];

   always_comb begin
      d_merged = d_word;
      for (int b = 0; b < BYTES; b++) begin
         if (d_byte_en[b]) begin
            d_merged[8*b +: 8] = d_write_data[8*b +: 8];
         end
      end
   end

   assign d_commit = d_accept && wEn && !d_oob;

   // A fetch colliding with a same-edge store sees the freshly merged word.
   assign i_fresh = i_oob ? '0 :
                    (d_commit && (d_idx == i_idx)) ? d_merged : mem[i_idx];
   assign d_fresh = d_oob ? '0 : (wEn ? d_merged : d_word);

   always_ff @(posedge clock) begin
      if (d_commit) begin
         mem[d_idx] <= d_merged;
      end
   end

   // Accept-time snapshot is held in *_pend until the response cycle publishes it.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         i_pend      <= '0;
         i_read_data <= '0;
         d_pend      <= '0;
         d_pend_err  <= 1'b0;
         d_read_data <= '0;
         d_err       <= 1'b0;
      end else begin
         if (i_accept) begin
            i_pend <= i_fresh;
         end
         if (i_load) begin
            i_read_data <= i_accept ? i_fresh : i_pend;
         end
         if (d_accept) begin
            d_pend     <= d_fresh;
            d_pend_err <= d_oob;
         end
         if (d_load) begin
            d_read_data <= d_accept ? d_fresh : d_pend;
         end
         d_err <= d_load ? (d_accept ? d_oob : d_pend_err) : 1'b0;
      end
   end

endmodule

// File: tb/tb_ram_latency_dual.sv
// tb/tb_ram_latency_dual.sv - scoreboard bench for ram_latency_dual
module tb_ram_latency_dual;

   localparam int DW        = 32;
   localparam int AW        = 16;
   localparam int IW        = 10;
   localparam int LAT       = 3;
   localparam int BE        = DW / 8;
   localparam int DEPTH     = 1 << IW;
   localparam int MEM_BYTES = DEPTH * BE;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          i_req = 1'b0;
   logic [AW-1:0] i_address = '0;
   logic          i_ready, i_valid;
   logic [DW-1:0] i_read_data;
   logic          d_req = 1'b0;
   logic          wEn = 1'b0;
   logic [BE-1:0] d_byte_en = '0;
   logic [AW-1:0] d_address = '0;
   logic [DW-1:0] d_write_data = '0;
   logic          d_ready, d_valid, d_err;
   logic [DW-1:0] d_read_data;

   always #5 clock = ~clock;

   ram_latency_dual #(
      .DATA_WIDTH   (DW),
      .ADDR_WIDTH   (AW),
      .INDEX_WIDTH  (IW),
      .READ_LATENCY (LAT)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .i_req        (i_req),
      .i_address    (i_address),
      .i_ready      (i_ready),
      .i_valid      (i_valid),
      .i_read_data  (i_read_data),
      .d_req        (d_req),
      .wEn          (wEn),
      .d_byte_en    (d_byte_en),
      .d_address    (d_address),
      .d_write_data (d_write_data),
      .d_ready      (d_ready),
      .d_valid      (d_valid),
      .d_read_data  (d_read_data),
      .d_err        (d_err)
   );

   typedef struct {
      logic [DW-1:0] data;
      logic          err;
      int            due;
   } exp_t;

   exp_t          iq[$];
   exp_t          dq[$];
   logic [DW-1:0] model [DEPTH];
   int            total = 0;
   int            bad = 0;
   int            cyc = 0;
   logic [DW-1:0] last_i = '0;
   logic [DW-1:0] last_d = '0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
      end
   endtask

   task automatic flag(input string name, input int a, input int b);
      total++;
      bad++;
      $display("FAIL %s: got %0d want %0d", name, a, b);
   endtask

   always @(negedge clock) begin : monitor
      exp_t e;
      if (!reset) begin
         iq.delete();
         dq.delete();
         last_i = '0;
         last_d = '0;
         check("rst_i_valid", i_valid, 1'b0);
         check("rst_d_valid", d_valid, 1'b0);
      end else begin
         while (iq.size() > 0 && iq[0].due < cyc) begin
            flag("i_missing_valid_cycle", cyc, iq[0].due);
            void'(iq.pop_front());
         end
         while (dq.size() > 0 && dq[0].due < cyc) begin
            flag("d_missing_valid_cycle", cyc, dq[0].due);
            void'(dq.pop_front());
         end
         if (i_valid) begin
            if (iq.size() == 0) begin
               flag("i_unexpected_valid_queue", 1, 0);
            end else begin
               e = iq.pop_front();
               check("i_valid_cycle", cyc, e.due);
               check("i_read_data", i_read_data, e.data);
               last_i = e.data;
            end
         end else begin
            check("i_read_data_hold", i_read_data, last_i);
         end
         if (d_valid) begin
            if (dq.size() == 0) begin
               flag("d_unexpected_valid_queue", 1, 0);
            end else begin
               e = dq.pop_front();
               check("d_valid_cycle", cyc, e.due);
               check("d_read_data", d_read_data, e.data);
               check("d_err", d_err, e.err);
               last_d = e.data;
            end
         end else begin
            check("d_read_data_hold", d_read_data, last_d);
         end
      end
   end

   // Reference: D side applied before I side so a same-edge fetch sees the store.
   task automatic model_d(input int due);
      int            a;
      logic [DW-1:0] w;
      a = int'(d_address);
      if (a >= MEM_BYTES) begin
         dq.push_back('{data: '0, err: 1'b1, due: due});
      end else if (wEn) begin
         w = model[a / BE];
         for (int b = 0; b < BE; b++) begin
            if (d_byte_en[b]) w[8*b +: 8] = d_write_data[8*b +: 8];
         end
         model[a / BE] = w;
         dq.push_back('{data: w, err: 1'b0, due: due});
      end else begin
         dq.push_back('{data: model[a / BE], err: 1'b0, due: due});
      end
   endtask

   task automatic model_i(input int due);
      int a;
      a = int'(i_address);
      iq.push_back('{data: (a >= MEM_BYTES) ? '0 : model[a / BE], err: 1'b0, due: due});
   endtask

   task automatic tick(output bit i_acc, output bit d_acc);
      @(negedge clock);
      i_acc = i_req && i_ready && reset;
      d_acc = d_req && d_ready && reset;
      if (d_acc) model_d(cyc + LAT);
      if (i_acc) model_i(cyc + LAT);
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int n);
      bit ia, da;
      i_req = 1'b0;
      d_req = 1'b0;
      repeat (n) tick(ia, da);
   endtask

   task automatic d_issue(input bit we, input logic [BE-1:0] be,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wd);
      bit ia, da;
      int n;
      n = 0;
      wEn = we;
      d_byte_en = be;
      d_address = addr;
      d_write_data = wd;
      d_req = 1'b1;
      do begin
         tick(ia, da);
         n++;
      end while (!da && n < 50);
      if (!da) flag("d_accept_timeout", n, 50);
      d_req = 1'b0;
   endtask

   task automatic i_until_accept(input logic [AW-1:0] addr);
      bit ia, da;
      int n;
      n = 0;
      i_address = addr;
      i_req = 1'b1;
      do begin
         tick(ia, da);
         n++;
      end while (!ia && n < 50);
      if (!ia) flag("i_accept_timeout", n, 50);
   endtask

   task automatic hold_reset;
      reset = 1'b0;
      i_req = 1'b0;
      d_req = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_i_ready", i_ready, 1'b1);
      check("rst_d_ready", d_ready, 1'b1);
      check("rst_i_read_data", i_read_data, '0);
      check("rst_d_read_data", d_read_data, '0);
      check("rst_d_err", d_err, 1'b0);
      @(posedge clock);
      #1;
      reset = 1'b1;
   endtask

   function automatic logic [AW-1:0] rand_addr();
      if ($urandom_range(7, 0) == 0) return AW'($urandom_range(65535, MEM_BYTES));
      return AW'($urandom_range(MEM_BYTES - 1, 0));
   endfunction

   initial begin
      bit ia, da;
      hold_reset();

      for (int k = 0; k < DEPTH; k++) begin
         d_issue(1'b1, '1, AW'(k * BE), $urandom());
      end
      idle(LAT + 2);

      d_issue(1'b1, 4'hF, 16'd8, 32'hDEADBEEF);
      d_issue(1'b0, 4'hF, 16'd8, 32'h0);
      d_issue(1'b1, 4'b0001, 16'd8, 32'h000000AA);
      d_issue(1'b0, 4'h0, 16'd8, 32'h0);
      idle(LAT + 1);

      i_address = 16'd8;
      i_req = 1'b1;
      wEn = 1'b1;
      d_byte_en = 4'hF;
      d_address = 16'd8;
      d_write_data = 32'h12345678;
      d_req = 1'b1;
      tick(ia, da);
      check("collide_i_accept", ia, 1'b1);
      check("collide_d_accept", da, 1'b1);
      idle(LAT + 1);

      d_issue(1'b0, 4'hF, 16'h1000, 32'h0);
      d_issue(1'b1, 4'hF, 16'h1000, 32'hCAFEF00D);
      d_issue(1'b0, 4'hF, 16'h0000, 32'h0);
      i_until_accept(16'hFFFC);
      idle(LAT + 1);

      i_until_accept(16'd0);
      i_until_accept(16'd4);
      tick(ia, da);
      reset = 1'b0;
      i_req = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b1;
      @(negedge clock);
      check("post_reset_i_ready", i_ready, 1'b1);
      @(posedge clock);
      #1;
      idle(LAT + 2);

      for (int n = 0; n < 3000; n++) begin
         i_req = 1'($urandom_range(1, 0));
         i_address = rand_addr();
         d_req = 1'($urandom_range(1, 0));
         wEn = 1'($urandom_range(1, 0));
         d_byte_en = BE'($urandom());
         d_address = rand_addr();
         d_write_data = $urandom();
         tick(ia, da);
      end

      idle(LAT + 3);
      check("iq_drained", iq.size(), 0);
      check("dq_drained", dq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
